// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the glitch-free clock-switch sequencer.
package clk_switch_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    WAIT_LOCK  = 3'd2,
    SWITCH     = 3'd3,
    SETTLE     = 3'd4,
    RELEASE    = 3'd5
  } state_t;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clk_switch_lock_sync.sv
// N-flop synchronizer for an asynchronous PLL lock indication.
module clk_switch_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i) begin
    if (rst_i) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d_i};
  end

  assign q_o = ff[STAGES-1];

endmodule

// File: rtl/clk_switch_seq.sv
// Sequences the clock-mux select between two PLLs, holding the muxed domain
// in reset across the switch and supervising lock of the active source.
module clk_switch_seq
  import clk_switch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int LOCK_CYCLES     = 16,
  parameter int SETTLE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic lock0_i,
  input  logic lock1_i,
  input  logic err_clr_i,
  output logic clk_sel_o,
  output logic domain_rst_o,
  output logic busy_o,
  output logic err_o
);

  localparam int HOLD_MAX = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int HOLD_W   = cnt_w(HOLD_MAX);
  localparam int LOCK_W   = cnt_w(LOCK_CYCLES);
  localparam int TMO_W    = cnt_w(TIMEOUT_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] SETTLE_LAST = HOLD_W'(SETTLE_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic              target;
  logic [HOLD_W-1:0] cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [1:0]        lock_s;
  logic              cur_lock, tgt_lock;

  clk_switch_lock_sync #(.STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({lock1_i, lock0_i}),
    .q_o   (lock_s)
  );

  assign cur_lock    = lock_s[clk_sel_o];
  assign tgt_lock    = lock_s[target];
  assign req_ready_o = (state == IDLE) && cur_lock;
  assign busy_o      = (state != IDLE);

  // Counters default to zero every cycle and only advance in the state that
  // owns them, so any state change leaves them cleared for the next entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= WAIT_LOCK;
      target       <= 1'b0;
      clk_sel_o    <= 1'b0;
      domain_rst_o <= 1'b1;
      err_o        <= 1'b0;
      cnt          <= '0;
      lock_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      cnt      <= '0;
      lock_cnt <= '0;
      tmo_cnt  <= '0;
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!cur_lock) begin
            state        <= WAIT_LOCK;
            target       <= clk_sel_o;
            domain_rst_o <= 1'b1;
          end else if (req_valid_i && (req_sel_i != clk_sel_o)) begin
            state        <= ASSERT_RST;
            target       <= req_sel_i;
            domain_rst_o <= 1'b1;
          end
        end
        ASSERT_RST: begin
          if (cnt == HOLD_LAST) state <= WAIT_LOCK;
          else                  cnt   <= cnt + HOLD_W'(1);
        end
        WAIT_LOCK: begin
          if (tgt_lock && (lock_cnt == LOCK_LAST)) begin
            state <= SWITCH;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort a switch back to the current source; a stuck current
            // source just keeps retrying with the error flagged.
            err_o <= 1'b1;
            if (target != clk_sel_o) begin
              target <= clk_sel_o;
              state  <= SETTLE;
            end
          end else begin
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
            lock_cnt <= tgt_lock ? lock_cnt + LOCK_W'(1) : '0;
          end
        end
        SWITCH: begin
          clk_sel_o <= target;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state        <= RELEASE;
            domain_rst_o <= 1'b0;
          end else begin
            cnt <= cnt + HOLD_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_seq.sv
// Directed bench for clk_switch_seq: boot, switch, glitch, timeout, lock loss, reset.
module tb_clk_switch_seq;

  logic clk_i = 1'b0;
  logic rst_i, req_valid_i, req_sel_i, lock0_i, lock1_i, err_clr_i;
  logic req_ready_o, clk_sel_o, domain_rst_o, busy_o, err_o;
  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  clk_switch_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_sel_i    (req_sel_i),
    .req_ready_o  (req_ready_o),
    .lock0_i      (lock0_i),
    .lock1_i      (lock1_i),
    .err_clr_i    (err_clr_i),
    .clk_sel_o    (clk_sel_o),
    .domain_rst_o (domain_rst_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_sel_i = 1'b0;
    lock0_i = 1'b1; lock1_i = 1'b0; err_clr_i = 1'b0;

    // reset state
    step(3);
    chk("rst_sel", clk_sel_o, 1'b0);
    chk("rst_drst", domain_rst_o, 1'b1);
    chk("rst_err", err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_ready", req_ready_o, 1'b0);

    // boot on source 0
    rst_i = 1'b0;
    step(26);
    chk("boot_drst_c26", domain_rst_o, 1'b1);
    step(1);
    chk("boot_drst_c27", domain_rst_o, 1'b0);
    chk("boot_ready_c27", req_ready_o, 1'b0);
    step(1);
    chk("boot_ready_c28", req_ready_o, 1'b1);
    chk("boot_busy_c28", busy_o, 1'b0);
    chk("boot_sel", clk_sel_o, 1'b0);

    // same-select request is only acknowledged
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    chk("same_ready", req_ready_o, 1'b1);
    step(1);
    req_valid_i = 1'b0;
    chk("same_busy", busy_o, 1'b0);
    chk("same_drst", domain_rst_o, 1'b0);
    step(2);
    chk("same_busy2", busy_o, 1'b0);

    // switch to source 1, lock1 rising as WAIT_LOCK is entered
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    chk("sw_drst_a0", domain_rst_o, 1'b1);
    chk("sw_busy_a0", busy_o, 1'b1);
    step(4);
    lock1_i = 1'b1;
    step(18);
    chk("sw_sel_a22", clk_sel_o, 1'b0);
    step(1);
    chk("sw_sel_a23", clk_sel_o, 1'b1);
    chk("sw_drst_a23", domain_rst_o, 1'b1);
    step(7);
    chk("sw_drst_a30", domain_rst_o, 1'b1);
    step(1);
    chk("sw_drst_a31", domain_rst_o, 1'b0);
    chk("sw_err", err_o, 1'b0);
    step(1);
    chk("sw_ready_a32", req_ready_o, 1'b1);

    // switch back to 0 with a one-cycle lock glitch after 10 high cycles
    lock0_i = 1'b0;
    step(3);
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    step(1);
    req_valid_i = 1'b0;
    step(4);
    lock0_i = 1'b1;
    step(10);
    lock0_i = 1'b0;
    step(1);
    lock0_i = 1'b1;
    step(18);
    chk("gl_sel_b33", clk_sel_o, 1'b1);
    step(1);
    chk("gl_sel_b34", clk_sel_o, 1'b0);
    step(8);
    chk("gl_drst_b42", domain_rst_o, 1'b0);
    step(1);
    chk("gl_ready_b43", req_ready_o, 1'b1);

    // timeout on source 1; err_clr in the timeout cycle must lose
    lock1_i = 1'b0;
    step(3);
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    step(4 + 1023);
    chk("to_err_pre", err_o, 1'b0);
    chk("to_busy_pre", busy_o, 1'b1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    chk("to_err_set", err_o, 1'b1);
    chk("to_sel", clk_sel_o, 1'b0);
    step(7);
    chk("to_drst_settle", domain_rst_o, 1'b1);
    step(1);
    chk("to_drst_rel", domain_rst_o, 1'b0);
    step(1);
    chk("to_busy_idle", busy_o, 1'b0);
    chk("to_sel_idle", clk_sel_o, 1'b0);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    chk("to_err_clr", err_o, 1'b0);

    // loss of the active lock in IDLE
    lock0_i = 1'b0;
    step(2);
    chk("ll_ready", req_ready_o, 1'b0);
    step(1);
    chk("ll_drst", domain_rst_o, 1'b1);
    chk("ll_busy", busy_o, 1'b1);
    lock0_i = 1'b1;
    for (int i = 0; i < 200 && busy_o; i++) step(1);
    chk("ll_recover_busy", busy_o, 1'b0);
    chk("ll_recover_sel", clk_sel_o, 1'b0);
    chk("ll_err", err_o, 1'b0);

    // reset pulse in SETTLE after switching to 1
    lock1_i = 1'b1;
    step(3);
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    step(20);
    chk("rs_sel_a20", clk_sel_o, 1'b0);
    step(1);
    chk("rs_sel_a21", clk_sel_o, 1'b1);
    chk("rs_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("rs_sel_rst", clk_sel_o, 1'b0);
    chk("rs_drst_rst", domain_rst_o, 1'b1);
    chk("rs_busy_rst", busy_o, 1'b1);
    chk("rs_ready_rst", req_ready_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
